// File: rtl/aes_decryptor.sv
// Iterative AES-128 decryptor: expands the cipher key forward to round key 10,
// then runs one inverse round step per cycle, unwinding the key schedule on the fly.
module aes_decryptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic [127:0] plain_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT_ARK, INV_SR, INV_SB, ARK, INV_MC, DONE} fsm_t;
    // Element k of a block is FIPS-197 byte k (row k%4, column k/4).
    typedef logic [0:15][7:0] blk_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    // Byte x sits at bits [(255-x)*8 +: 8]; 255-x is simply ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(r), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(r), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, a1, a2, a3);
        logic [7:0] m09 [4], m0b [4], m0d [4], m0e [4];
        logic [7:0] a [4];
        a = '{a0, a1, a2, a3};
        for (int i = 0; i < 4; i++) begin
            m09[i] = xt(xt(xt(a[i]))) ^ a[i];
            m0b[i] = xt(xt(xt(a[i]))) ^ xt(a[i]) ^ a[i];
            m0d[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ a[i];
            m0e[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
        end
        return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
                m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
    endfunction

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] key_q, key_d, plain_q, plain_d, ark_key;
    blk_t         state_q, state_d, isr_out, isb_out, mc_out;
    logic         busy_q, busy_d, done_q, done_d;

    assign isr_out = {state_q[0],  state_q[13], state_q[10], state_q[7],
                      state_q[4],  state_q[1],  state_q[14], state_q[11],
                      state_q[8],  state_q[5],  state_q[2],  state_q[15],
                      state_q[12], state_q[9],  state_q[6],  state_q[3]};

    for (genvar i = 0; i < 16; i++) begin : g_isb
        assign isb_out[i] = inv_sbox(state_q[i]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign {mc_out[4*c], mc_out[4*c+1], mc_out[4*c+2], mc_out[4*c+3]} =
            inv_mix_col(state_q[4*c], state_q[4*c+1], state_q[4*c+2], state_q[4*c+3]);
    end

    // In ARK the key register holds round key round_q+1; step it back one round.
    assign ark_key = prev_key(key_q, round_q);

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        key_d   = key_q;
        state_d = state_q;
        plain_d = plain_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    fsm_d   = KEYEXP;
                    round_d = 4'd0;
                    key_d   = key_in;
                    state_d = cipher_in;
                end else begin
                    fsm_d = IDLE;
                end
            end
            KEYEXP: begin
                key_d = next_key(key_q, round_q);
                if (round_q == 4'd9) fsm_d = INIT_ARK;
                else                 round_d = round_q + 4'd1;
            end
            INIT_ARK: begin
                state_d = state_q ^ key_q;
                round_d = 4'd9;
                fsm_d   = INV_SR;
            end
            INV_SR: begin
                state_d = isr_out;
                fsm_d   = INV_SB;
            end
            INV_SB: begin
                state_d = isb_out;
                fsm_d   = ARK;
            end
            ARK: begin
                state_d = state_q ^ ark_key;
                key_d   = ark_key;
                if (round_q == 4'd0) begin
                    fsm_d   = DONE;
                    plain_d = state_q ^ ark_key;
                end else begin
                    fsm_d = INV_MC;
                end
            end
            INV_MC: begin
                state_d = mc_out;
                round_d = round_q - 4'd1;
                fsm_d   = INV_SR;
            end
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d != IDLE) && (fsm_d != DONE);
        done_d = (fsm_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
            state_q <= '0;
            plain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            key_q   <= key_d;
            state_q <= state_d;
            plain_q <= plain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign plain_out = plain_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_decryptor.sv
// Bench for aes_decryptor: directed FIPS-197 vectors, timing/abort scenarios and
// random blocks encrypted by an independent forward AES model built from GF(2^8) math.
module tb_aes_decryptor;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_in;
    logic [127:0] key_in;
    logic [127:0] plain_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_decryptor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .plain_out (plain_out),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[8'(a)] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [0:15][7:0] kb, pb, ob;
        logic [7:0] rk [11][16];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        kb = key;
        pb = pt;
        rc = 8'h01;
        for (int k = 0; k < 16; k++) rk[0][4'(k)] = kb[4'(k)];
        for (int i = 1; i <= 10; i++) begin
            for (int j = 0; j < 4; j++)
                rk[4'(i)][4'(j)] = rk[4'(i-1)][4'(j)] ^ sb[rk[4'(i-1)][4'(12 + (j + 1) % 4)]]
                                   ^ ((j == 0) ? rc : 8'h00);
            for (int k = 4; k < 16; k++)
                rk[4'(i)][4'(k)] = rk[4'(i-1)][4'(k)] ^ rk[4'(i)][4'(k-4)];
            rc = gmul(rc, 8'h02);
        end
        for (int k = 0; k < 16; k++) s[4'(k)] = pb[4'(k)] ^ rk[0][4'(k)];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++)
                t[4'(k)] = sb[s[4'(4 * ((k / 4 + k % 4) % 4) + k % 4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < 10)
                        s[4'(4*c + r)] = gmul(8'h02, t[4'(4*c + r)]) ^ gmul(8'h03, t[4'(4*c + (r+1) % 4)])
                                       ^ t[4'(4*c + (r+2) % 4)] ^ t[4'(4*c + (r+3) % 4)];
                    else
                        s[4'(4*c + r)] = t[4'(4*c + r)];
            for (int k = 0; k < 16; k++) s[4'(k)] = s[4'(k)] ^ rk[4'(rnd)][4'(k)];
        end
        for (int k = 0; k < 16; k++) ob[4'(k)] = s[4'(k)];
        return ob;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key);
        cipher_in = ct;
        key_in    = key;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [127:0] exp_plain,
                         input logic [127:0] prev_plain, input int disturb_at);
        for (int n = 0; n <= 53; n++) begin
            if (n > 0) step();
            checkOutput($sformatf("%s busy@%0d", tag, n), 128'(busy), 128'(n <= 49));
            checkOutput($sformatf("%s done@%0d", tag, n), 128'(done), 128'(n == 50));
            if (n == 25) checkOutput($sformatf("%s plain held@%0d", tag, n), plain_out, prev_plain);
            if (n == 50 || n == 53) checkOutput($sformatf("%s plain@%0d", tag, n), plain_out, exp_plain);
            if (n == disturb_at) begin
                start     = 1'b1;
                cipher_in = {$urandom, $urandom, $urandom, $urandom};
                key_in    = {$urandom, $urandom, $urandom, $urandom};
            end else if (n == disturb_at + 1) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [127:0] rkey, rpt, rct;
        int lat;
        int done_cnt;

        rst       = 1'b1;
        start     = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        buildSbox();
        repeat (2) @(negedge clk);
        checkOutput("reset plain", plain_out, 128'h0);
        checkOutput("reset busy", 128'(busy), 128'h0);
        checkOutput("reset done", 128'(done), 128'h0);
        rst = 1'b0;
        step();

        applyStimulus(CT_A, KEY_A);
        runOp("vecA", PT_A, 128'h0, 1000);

        applyStimulus(CT_A, KEY_A);
        runOp("vecA disturbed", PT_A, PT_A, 20);

        applyStimulus(CT_B, KEY_B);
        runOp("vecB", PT_B, PT_A, 1000);

        applyStimulus(CT_B, KEY_B);
        repeat (30) step();
        rst = 1'b1;
        #1;
        checkOutput("abort plain", plain_out, 128'h0);
        checkOutput("abort busy", 128'(busy), 128'h0);
        checkOutput("abort done", 128'(done), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 55; n++) begin
            step();
            if (done) done_cnt++;
        end
        checkOutput("abort no done", 128'(done_cnt), 128'h0);
        checkOutput("abort busy after", 128'(busy), 128'h0);
        checkOutput("abort plain after", plain_out, 128'h0);
        applyStimulus(CT_B, KEY_B);
        runOp("vecB after abort", PT_B, 128'h0, 1000);

        // start held high: re-accepted straight out of DONE
        cipher_in = CT_A;
        key_in    = KEY_A;
        start     = 1'b1;
        step();
        for (int n = 0; n <= 103; n++) begin
            if (n > 0) step();
            checkOutput($sformatf("b2b busy@%0d", n), 128'(busy),
                        128'(n <= 49 || (n >= 51 && n <= 100)));
            checkOutput($sformatf("b2b done@%0d", n), 128'(done), 128'(n == 50 || n == 101));
            if (n == 25) checkOutput("b2b plain held", plain_out, PT_B);
            if (n == 50 || n == 75 || n == 101)
                checkOutput($sformatf("b2b plain@%0d", n), plain_out, PT_A);
            if (n == 101) start = 1'b0;
        end

        for (int i = 0; i < 1000; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rct  = encrypt(rpt, rkey);
            applyStimulus(rct, rkey);
            lat = -1;
            for (int n = 1; n <= 60; n++) begin
                step();
                if (done) begin
                    lat = n;
                    break;
                end
            end
            checkOutput($sformatf("rand%0d latency", i), 128'(lat), 128'(50));
            checkOutput($sformatf("rand%0d plain", i), plain_out, rpt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
